// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Purpose:
//   Shares one single-port synchronous memory between the instruction-fetch
//   port (i_*) and the load/store data port (d_*). Data accesses win
//   contention, but a streak counter caps consecutive data grants while a
//   fetch is waiting, so fetch always makes progress. Read data returns one
//   cycle after the grant and is steered to the port that owns it.
//
// Handshake (both ports): a requester holds req/addr/we/wdata stable until it
//   samples gnt=1 at a rising clk edge. gnt is combinational in the same
//   cycle, and at most one gnt is high per cycle. A granted read is answered
//   by rvalid=1 with rdata in the following cycle; granted writes return no
//   rvalid.
//
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   i_req/i_addr            fetch request and byte address
//   i_gnt/i_rvalid/i_rdata  fetch accept, fetch data valid, fetch data
//   d_req/d_we/d_addr/d_wdata  data request, write enable, address, write data
//   d_gnt/d_rvalid/d_rdata  data accept, load data valid, load data
//   mem_en/mem_we/mem_addr/mem_wdata  memory access towards the RAM
//   mem_rdata               RAM read data, valid one cycle after a read
//   stat_i_grants/stat_d_grants/stat_conflicts  (ARB_STATS_EN only)
//                           wrapping 32-bit grant and contention counters
//
// Configuration:
//   ARB_STATS_EN  define to add the three statistics counters and ports.
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stat_i_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_conflicts
`endif
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] r_streak;
    logic          r_rvalid;
    logic          r_rvalid_owner;   // 1 = returning data belongs to data port
    logic          w_streak_full;
    logic          w_i_gnt;
    logic          w_d_gnt;

    assign w_streak_full = (r_streak == STREAK_MAX);

    // Grants are gated by reset so nothing reaches the memory while reset is
    // held, even though the request inputs may still be active.
    assign w_d_gnt = reset & d_req & (~i_req | ~w_streak_full);
    assign w_i_gnt = reset & i_req & ~w_d_gnt;

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_i_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr;
        end
    end

    // Streak only counts data grants that actually delayed a pending fetch;
    // any cycle without a fetch request wipes the history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_streak <= '0;
        end else if (!i_req || w_i_gnt) begin
            r_streak <= '0;
        end else if (w_d_gnt && !w_streak_full) begin
            r_streak <= r_streak + SW'(1);
        end
    end

    // One grant per cycle means one response slot is enough; the owner bit
    // steers it to the right port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvalid       <= 1'b0;
            r_rvalid_owner <= 1'b0;
        end else begin
            r_rvalid       <= w_i_gnt | (w_d_gnt & ~d_we);
            r_rvalid_owner <= w_d_gnt;
        end
    end

    assign i_rvalid = r_rvalid & ~r_rvalid_owner;
    assign d_rvalid = r_rvalid &  r_rvalid_owner;
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_i_grants;
    logic [31:0] r_stat_d_grants;
    logic [31:0] r_stat_conflicts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_i_grants  <= '0;
            r_stat_d_grants  <= '0;
            r_stat_conflicts <= '0;
        end else begin
            if (w_i_gnt)       r_stat_i_grants  <= r_stat_i_grants + 32'd1;
            if (w_d_gnt)       r_stat_d_grants  <= r_stat_d_grants + 32'd1;
            if (i_req & d_req) r_stat_conflicts <= r_stat_conflicts + 32'd1;
        end
    end

    assign stat_i_grants  = r_stat_i_grants;
    assign stat_d_grants  = r_stat_d_grants;
    assign stat_conflicts = r_stat_conflicts;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Bench for unified_mem_arbiter with a behavioural single-port RAM attached.
// Inputs change #1 after the rising edge; outputs are sampled on the falling
// edge. A scoreboard pushes the expected read data (from a shadow copy of the
// RAM contents kept by the bench) whenever a read is granted, and pops and
// compares it when the matching rvalid appears.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef ARB_STATS_EN
    logic [31:0]   stat_i_grants;
    logic [31:0]   stat_d_grants;
    logic [31:0]   stat_conflicts;
`endif

    int checks;
    int failures;

    logic [DW-1:0] i_exp_q[$];
    logic [DW-1:0] d_exp_q[$];
    logic [DW-1:0] shadow [0:255];

    unified_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4)
    ) dut (
        .clk(clk), .reset(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM model (256 words, backdoor preload) ----------------
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ram_q;
    logic          bd_we;
    logic [7:0]    bd_idx;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_idx] <= bd_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
            else        ram_q <= ram[mem_addr[9:2]];
        end
    end
    assign mem_rdata = ram_q;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (i_gnt && d_gnt) begin
                failures++;
                $display("FAIL gnt_onehot: i_gnt=%b d_gnt=%b required at most one", i_gnt, d_gnt);
            end
            checks++;
            if (i_rvalid && d_rvalid) begin
                failures++;
                $display("FAIL rvalid_onehot: i_rvalid=%b d_rvalid=%b required at most one", i_rvalid, d_rvalid);
            end
            if (i_rvalid) begin
                checks++;
                if (i_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL i_rvalid_unexpected: i_rvalid=1 with no outstanding fetch");
                end else begin
                    logic [DW-1:0] exp_v;
                    exp_v = i_exp_q.pop_front();
                    if (i_rdata !== exp_v) begin
                        failures++;
                        $display("FAIL i_rdata: got %h expected %h", i_rdata, exp_v);
                    end
                end
            end
            if (d_rvalid) begin
                checks++;
                if (d_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL d_rvalid_unexpected: d_rvalid=1 with no outstanding load");
                end else begin
                    logic [DW-1:0] exp_v;
                    exp_v = d_exp_q.pop_front();
                    if (d_rdata !== exp_v) begin
                        failures++;
                        $display("FAIL d_rdata: got %h expected %h", d_rdata, exp_v);
                    end
                end
            end
            if (i_gnt)           i_exp_q.push_back(shadow[i_addr[9:2]]);
            if (d_gnt && !d_we)  d_exp_q.push_back(shadow[d_addr[9:2]]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [DW-1:0] data);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = data;
        shadow[idx] = data;
        next_cycle();
        bd_we   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bd_we = 1'b0;
        bd_idx = '0;
        bd_data = '0;
        set_idle();
        for (int k = 0; k < 256; k++) begin
            if (k == 2) preload(8'(k), 32'hE3A0_0007);
            else        preload(8'(k), $urandom);
        end
        // requests held during reset must not be granted
        i_req = 1'b1;
        d_req = 1'b1;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt: i_gnt=%b d_gnt=%b mem_en=%b required 0", i_gnt, d_gnt, mem_en);
        end
        checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rvalid: i_rvalid=%b d_rvalid=%b required 0", i_rvalid, d_rvalid);
        end
        next_cycle();
        set_idle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_idle();
        d_req = 1'b0;
        d_we  = 1'b1;           // ignored without d_req
        d_addr = 32'h0000_0044;
        d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL idle_mem: en=%b we=%b addr=%h wdata=%h required all 0", mem_en, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL idle_rdata: i_rdata=%h d_rdata=%h required 0", i_rdata, d_rdata);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_fetch_only();
        i_req  = 1'b1;
        i_addr = 32'h0000_0008;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            failures++;
            $display("FAIL fetch_gnt: i_gnt=%b d_gnt=%b required 1/0", i_gnt, d_gnt);
        end
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h8) begin
            failures++;
            $display("FAIL fetch_mem: en=%b we=%b addr=%h required 1/0/00000008", mem_en, mem_we, mem_addr);
        end
        next_cycle();
        set_idle();
        @(negedge clk);
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hE3A0_0007 || d_gnt !== 1'b0) begin
            failures++;
            $display("FAIL fetch_resp: i_rvalid=%b i_rdata=%h d_gnt=%b required 1/e3a00007/0", i_rvalid, i_rdata, d_gnt);
        end
        next_cycle();
    endtask

    task automatic test_data_write_read();
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h0000_0064;
        d_wdata = 32'd7;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h64 || mem_wdata !== 32'd7) begin
            failures++;
            $display("FAIL write_mem: d_gnt=%b we=%b addr=%h wdata=%h required 1/1/00000064/00000007", d_gnt, mem_we, mem_addr, mem_wdata);
        end
        shadow[8'h19] = 32'd7;
        next_cycle();
        d_we = 1'b0;
        d_wdata = '0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0 || d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL write_no_rvalid: d_rvalid=%b d_gnt=%b required 0/1", d_rvalid, d_gnt);
        end
        next_cycle();
        set_idle();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'd7) begin
            failures++;
            $display("FAIL read_back: d_rvalid=%b d_rdata=%h required 1/00000007", d_rvalid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_contention();
`ifdef ARB_STATS_EN
        logic [31:0] s_i0, s_d0, s_c0;
`endif
        // one idle cycle so the streak starts from zero
        set_idle();
        next_cycle();
`ifdef ARB_STATS_EN
        s_i0 = stat_i_grants;
        s_d0 = stat_d_grants;
        s_c0 = stat_conflicts;
`endif
        for (int k = 0; k < 10; k++) begin
            logic exp_i;
            exp_i = (k % 5 == 4);
            i_req = 1'b1;
            i_addr = 32'h0000_0010;
            d_req = 1'b1;
            d_we = 1'b0;
            d_addr = 32'h0000_0040;
            @(negedge clk);
            checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
                failures++;
                $display("FAIL contention_seq[%0d]: i_gnt=%b d_gnt=%b required %b/%b", k, i_gnt, d_gnt, exp_i, !exp_i);
            end
            next_cycle();
        end
        set_idle();
`ifdef ARB_STATS_EN
        checks++;
        if (stat_d_grants - s_d0 !== 32'd8 || stat_i_grants - s_i0 !== 32'd2 || stat_conflicts - s_c0 !== 32'd10) begin
            failures++;
            $display("FAIL stats: d=%0d i=%0d c=%0d required 8/2/10", stat_d_grants - s_d0, stat_i_grants - s_i0, stat_conflicts - s_c0);
        end
`endif
        next_cycle();
    endtask

    task automatic test_streak_reset();
        set_idle();
        next_cycle();
        // 3 contended data grants, 1 cycle without fetch, then 5 contended
        for (int k = 0; k < 9; k++) begin
            logic exp_i;
            exp_i = (k == 8);
            i_req = (k != 3);
            i_addr = 32'h0000_0020;
            d_req = 1'b1;
            d_we = 1'b0;
            d_addr = 32'h0000_0030;
            @(negedge clk);
            checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
                failures++;
                $display("FAIL streak_reset[%0d]: i_gnt=%b d_gnt=%b required %b/%b", k, i_gnt, d_gnt, exp_i, !exp_i);
            end
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_0064;
        i_req = 1'b1;
        i_addr = 32'h0000_0004;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL midrst_gnt: d_gnt=%b required 1", d_gnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d_rvalid !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs: d_rvalid=%b i_gnt=%b d_gnt=%b mem_en=%b required 0", d_rvalid, i_gnt, d_gnt, mem_en);
        end
        // the read cut off by reset is abandoned
        d_exp_q.delete();
        i_exp_q.delete();
        next_cycle();
        set_idle();
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_stale[%0d]: d_rvalid=%b i_rvalid=%b required 0", k, d_rvalid, i_rvalid);
            end
            next_cycle();
        end
        d_req = 1'b1;
        d_addr = 32'h0000_0064;
        next_cycle();
        set_idle();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'd7) begin
            failures++;
            $display("FAIL midrst_reissue: d_rvalid=%b d_rdata=%h required 1/00000007", d_rvalid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic i_done, d_done;
        set_idle();
        for (int c = 0; c < 300; c++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1'b1;
                i_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1'b1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                d_wdata = $urandom;
            end
            @(negedge clk);
            i_done = i_gnt;
            d_done = d_gnt;
            checks++;
            if ((i_req || d_req) && !(i_gnt || d_gnt)) begin
                failures++;
                $display("FAIL b2b_no_grant[%0d]: i_req=%b d_req=%b got no gnt", c, i_req, d_req);
            end
            checks++;
            if ((d_gnt && mem_addr !== d_addr) || (i_gnt && mem_addr !== i_addr)) begin
                failures++;
                $display("FAIL b2b_mem_addr[%0d]: mem_addr=%h i_addr=%h d_addr=%h", c, mem_addr, i_addr, d_addr);
            end
            if (d_gnt && d_we) shadow[d_addr[9:2]] = d_wdata;
            next_cycle();
            if (i_done) i_req = 1'b0;
            if (d_done) begin
                d_req = 1'b0;
                d_we = 1'($urandom_range(0, 1));
            end
        end
        set_idle();
        next_cycle();
        next_cycle();
        checks++;
        if (i_exp_q.size() != 0 || d_exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: i_pending=%0d d_pending=%0d required 0", i_exp_q.size(), d_exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_idle();
        test_fetch_only();
        test_data_write_read();
        test_contention();
        test_streak_reset();
        test_reset_mid_read();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
